// File: rtl/aes_inv_key_gen.sv
// Inverse AES-128 key schedule: loads the last round key and walks back to round 0, one key per handshake.
// Optional round-key cache with replay is enabled by defining AES_INV_KEY_CACHE_EN.
module aes_inv_key_gen #(
  parameter int         NRND     = 10,
  parameter logic [7:0] RCON_LST = 8'h36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] key_last_i,
  output logic [127:0] key_o,
  output logic [3:0]   rnd_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [31:0]  sub_o,
  input  logic [31:0]  sub_i
`ifdef AES_INV_KEY_CACHE_EN
  ,
  input  logic         reuse_i,
  output logic         cache_valid_o
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [127:0] key_reg;
  logic [3:0]   rnd;
  logic [7:0]   rcon;

  logic [31:0]  c0, c1, c2, c3, p0, p1, p2, p3, rot;
  logic [127:0] prev, load_key, next_key;
  logic         xfer, start_ok;

  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

  // w[i-4] = w[i] ^ w[i-1] for the three non-leading words; the leading word undoes SubWord/Rcon.
  assign {c0, c1, c2, c3} = key_reg;
  assign p3   = c3 ^ c2;
  assign p2   = c2 ^ c1;
  assign p1   = c1 ^ c0;
  assign rot  = {p3[23:0], p3[31:24]};
  assign p0   = c0 ^ sub_i ^ {rcon, 24'h0};
  assign prev = {p0, p1, p2, p3};

  assign xfer     = (state == EMIT) && key_ready_i;
  assign start_ok = (state == IDLE) && start_i;

  assign key_o       = key_reg;
  assign rnd_o       = rnd;
  assign key_valid_o = (state == EMIT);
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] cache [NRND+1];
  logic         reuse;

  assign load_key = (reuse_i && cache_valid_o) ? cache[NRND] : key_last_i;
  assign next_key = reuse ? cache[rnd - 4'd1] : prev;
  // Replay never touches the S-box so the shared unit stays quiet.
  assign sub_o    = reuse ? 32'h0 : rot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reuse         <= 1'b0;
      cache_valid_o <= 1'b0;
    end else if (start_ok) begin
      reuse         <= reuse_i && cache_valid_o;
      cache_valid_o <= reuse_i && cache_valid_o;
    end else if (state == DONE) begin
      cache_valid_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) cache[rnd] <= key_reg;
  end
`else
  assign load_key = key_last_i;
  assign next_key = prev;
  assign sub_o    = rot;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_reg <= '0;
      rnd     <= '0;
      rcon    <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          key_reg <= load_key;
          rnd     <= 4'(NRND);
          rcon    <= RCON_LST;
          state   <= EMIT;
        end
        EMIT: if (xfer) begin
          if (rnd != 4'd0) begin
            key_reg <= next_key;
            rnd     <= rnd - 4'd1;
            rcon    <= inv_xtime(rcon);
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Directed bench for aes_inv_key_gen using the FIPS-197 AES-128 key expansion, with an S-box model on sub_o/sub_i.
module tb_aes_inv_key_gen;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic         key_ready_i = 1'b0;
  logic [127:0] key_last_i = '0;
  logic [127:0] key_o;
  logic [3:0]   rnd_o;
  logic         key_valid_o, busy_o, done_o;
  logic [31:0]  sub_o, sub_i;
`ifdef AES_INV_KEY_CACHE_EN
  logic         reuse_i = 1'b0;
  logic         cache_valid_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_key  [11];
  logic [7:0]   exp_rcon [11];

  always #5 clk = ~clk;

  aes_inv_key_gen dut (
    .clk(clk), .rst(rst), .start_i(start_i), .key_last_i(key_last_i),
    .key_o(key_o), .rnd_o(rnd_o), .key_valid_o(key_valid_o), .key_ready_i(key_ready_i),
    .busy_o(busy_o), .done_o(done_o), .sub_o(sub_o), .sub_i(sub_i)
`ifdef AES_INV_KEY_CACHE_EN
    , .reuse_i(reuse_i), .cache_valid_o(cache_valid_o)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] p);
    return {p[23:0], p[31:24]};
  endfunction

  always_comb sub_i = {sbox(sub_o[31:24]), sbox(sub_o[23:16]), sbox(sub_o[15:8]), sbox(sub_o[7:0])};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key"},   key_o, '0);
    chk({tag, "_rnd"},   rnd_o, '0);
    chk({tag, "_valid"}, key_valid_o, '0);
    chk({tag, "_busy"},  busy_o, '0);
    chk({tag, "_done"},  done_o, '0);
    chk({tag, "_sub"},   sub_o, '0);
  endtask

  // One run from start; optional stall, start pulse or reset at a given round (-1 = none).
  task automatic run(input logic [127:0] k, input bit reuse, input int stall_at,
                     input int pulse_at, input int rst_at);
    int er, stalls, cyc;
    logic [127:0] ek;
    er = 10; stalls = 0; cyc = 1;
    @(negedge clk);
    start_i = 1'b1; key_last_i = k;
`ifdef AES_INV_KEY_CACHE_EN
    reuse_i = reuse;
`endif
    @(negedge clk);
    start_i = 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
    reuse_i = 1'b0;
`endif
    while (er >= 0 && cyc < 40) begin
      ek = exp_key[er];
      chk("valid", key_valid_o, 1);
      chk("busy", busy_o, 1);
      chk("done_early", done_o, 0);
      chk("rnd", rnd_o, er);
      chk("key", key_o, ek);
      if (reuse) chk("sub_zero", sub_o, 0);
      else begin
        chk("sub", sub_o, rotw(ek[63:32] ^ ek[31:0]));
        if (er > 0) chk("rcon", dut.rcon, exp_rcon[er]);
      end
      start_i = 1'b0;
      if (er == rst_at) begin
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0; key_ready_i = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("no_done", done_o, 0);
          chk("idle", busy_o, 0);
        end
        return;
      end
      if (er == pulse_at) begin start_i = 1'b1; key_last_i = ~k; end
      if (er == stall_at && stalls < 3) begin key_ready_i = 1'b0; stalls++; end
      else begin key_ready_i = 1'b1; er--; end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0; key_ready_i = 1'b0;
    chk("done_cycle", cyc, 12 + stalls);
    chk("done", done_o, 1);
    chk("done_busy", busy_o, 1);
    chk("done_valid", key_valid_o, 0);
    @(negedge clk);
    chk("done_pulse", done_o, 0);
    chk("back_idle", busy_o, 0);
  endtask

  initial begin
    exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_rcon[0] = 8'h00; exp_rcon[1] = 8'h01; exp_rcon[2] = 8'h02; exp_rcon[3] = 8'h04;
    exp_rcon[4] = 8'h08; exp_rcon[5] = 8'h10; exp_rcon[6] = 8'h20; exp_rcon[7] = 8'h40;
    exp_rcon[8] = 8'h80; exp_rcon[9] = 8'h1b; exp_rcon[10] = 8'h36;

    repeat (2) @(negedge clk);
    chk_zero("reset");
`ifdef AES_INV_KEY_CACHE_EN
    chk("reset_cache_valid", cache_valid_o, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    key_ready_i = 1'b1;
    chk("idle_ready_no_effect", key_valid_o, 0);
    key_ready_i = 1'b0;

    run(exp_key[10], 1'b0, -1, -1, -1);
    run(exp_key[10], 1'b0, 7, 5, -1);
    run(exp_key[10], 1'b0, -1, -1, 4);
    run(exp_key[10], 1'b0, -1, -1, -1);
`ifdef AES_INV_KEY_CACHE_EN
    chk("cache_valid_set", cache_valid_o, 1);
    run('0, 1'b1, -1, -1, -1);
    chk("cache_valid_kept", cache_valid_o, 1);
    run(exp_key[10], 1'b0, -1, -1, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
